tlc_phase_ctrl: RTL and testbench

Parametrised N-phase traffic-light controller, the multi-approach successor of the two-road highway/farm controller. It has an internal cycle counter, per-phase demand latching, and min/max green timing. Phase 0 is the main road and rests in green when there is no other demand. Other phases are served round-robin, driven by their sensors. It sits between the sensor-conditioning logic and the lamp drivers.

---
 rtl/tlc_phase_ctrl.sv | 178 +++++++++++++++++
 tb/tb_tlc_phase_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_phase_ctrl.sv
// N-phase traffic-light controller: demand latching, round-robin service, min/max green timing.
// Optional flashing mode is compiled in with `define TLC_FLASH_EN.
module tlc_phase_ctrl #(
  parameter int NUM_PHASES = 4,
  parameter int GREEN_MIN  = 500000000,
  parameter int GREEN_MAX  = 1500000000,
  parameter int YELLOW     = 150000000,
  parameter int ALL_RED    = 50000000,
  parameter int CNT_W      = 31,
  localparam int PW        = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
`ifdef TLC_FLASH_EN
  input  logic                      flash,
`endif
  input  logic [NUM_PHASES-1:0]     demand,
  output logic [2*NUM_PHASES-1:0]   phase_sig,
  output logic [PW-1:0]             active_phase,
  output logic [2:0]                state,
  output logic [NUM_PHASES-1:0]     pending,
  output logic                      phase_start
);

`ifdef TLC_FLASH_EN
  typedef enum logic [2:0] {
    S_INIT = 3'd0, S_GREEN = 3'd1, S_YELLOW = 3'd2, S_ALLRED = 3'd3, S_FLASH = 3'd4
  } st_t;
`else
  typedef enum logic [2:0] {
    S_INIT = 3'd0, S_GREEN = 3'd1, S_YELLOW = 3'd2, S_ALLRED = 3'd3
  } st_t;
`endif

  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  st_t                   st;
  logic [CNT_W-1:0]      cnt;
  logic [PW-1:0]         nxt;
  logic [PW-1:0]         sel;
  logic [PW-1:0]         idx;
  logic [PW-1:0]         green_ph;
  logic [NUM_PHASES-1:0] act_oh;
  logic [NUM_PHASES-1:0] own_mask;
  logic [NUM_PHASES-1:0] clr_mask;
  logic [NUM_PHASES-1:0] pend_nxt;
  logic                  other;
  logic                  dem_act;
  logic                  green_done;
  logic                  go_green;
  logic                  flash_req;

`ifdef TLC_FLASH_EN
  logic                  tog;
  logic [CNT_W-1:0]      fcnt;
  assign flash_req = flash;
`else
  assign flash_req = 1'b0;
`endif

  assign state = st;

  always_comb begin
    act_oh = '0;
    act_oh[active_phase] = 1'b1;
    other      = |(pending & ~act_oh);
    dem_act    = |(demand & act_oh);
    green_done = (cnt >= GMIN_M1) &&
                 (other || (active_phase != '0 && !dem_act) ||
                  (cnt == GMAX_M1 && (other || active_phase != '0)));
    go_green   = (st == S_INIT || st == S_ALLRED) && (cnt == AR_M1) && !flash_req;
    green_ph   = (st == S_INIT) ? '0 : nxt;
    own_mask   = (st == S_GREEN) ? act_oh : '0;
    clr_mask   = '0;
    if (go_green) clr_mask[green_ph] = 1'b1;
    // Clearing the phase about to go green beats a same-cycle demand on it.
    pend_nxt   = (pending | (demand & ~own_mask)) & ~clr_mask;
  end

  // Round-robin pick: scanning downward lets the nearest following phase win.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = NUM_PHASES - 1; k >= 1; k--) begin
      idx = PW'((int'(active_phase) + k) % NUM_PHASES);
      if (pending[idx]) sel = idx;
    end
  end

  always_comb begin
    phase_sig = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (PW'(i) == active_phase) begin
        if (st == S_GREEN)       phase_sig[2*i +: 2] = 2'b10;
        else if (st == S_YELLOW) phase_sig[2*i +: 2] = 2'b01;
      end
    end
`ifdef TLC_FLASH_EN
    if (st == S_FLASH) phase_sig[1:0] = tog ? 2'b11 : 2'b01;
`endif
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      st           <= S_INIT;
      cnt          <= '0;
      active_phase <= '0;
      nxt          <= '0;
      pending      <= '0;
      phase_start  <= 1'b0;
`ifdef TLC_FLASH_EN
      tog          <= 1'b0;
      fcnt         <= '0;
`endif
    end else begin
      pending     <= pend_nxt;
      phase_start <= go_green;
      cnt         <= (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
      case (st)
        S_INIT, S_ALLRED: begin
          if (cnt == AR_M1) begin
            cnt <= '0;
`ifdef TLC_FLASH_EN
            if (flash) begin
              st           <= S_FLASH;
              active_phase <= '0;
              tog          <= 1'b0;
              fcnt         <= '0;
            end else
`endif
            begin
              st           <= S_GREEN;
              active_phase <= green_ph;
            end
          end
        end
        S_GREEN: begin
          if (green_done) begin
            st  <= S_YELLOW;
            cnt <= '0;
          end
        end
        S_YELLOW: begin
          // Next phase is frozen from the pending snapshot of the first yellow cycle.
          if (cnt == '0) nxt <= sel;
          if (cnt == YEL_M1) begin
            st  <= S_ALLRED;
            cnt <= '0;
          end
        end
`ifdef TLC_FLASH_EN
        S_FLASH: begin
          if (fcnt == YEL_M1) begin
            fcnt <= '0;
            tog  <= ~tog;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
          if (!flash) begin
            st  <= S_ALLRED;
            cnt <= '0;
            nxt <= '0;
          end
        end
`endif
        default: begin
          st  <= S_INIT;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlc_phase_ctrl.sv
// Bench for tlc_phase_ctrl: directed scenarios plus randomized demand against a behavioural model.
`timescale 1ns/1ps
module tb_tlc_phase_ctrl;
  localparam int NP   = 4;
  localparam int GMIN = 10;
  localparam int GMAX = 40;
  localparam int YEL  = 4;
  localparam int AR   = 2;
  localparam int CW   = 6;
  localparam int S_INIT = 0, S_GRN = 1, S_YEL = 2, S_RED = 3, S_FLS = 4;

  logic            Clk = 1'b0;
  logic            Rst_n = 1'b0;
  logic [NP-1:0]   demand = '0;
  logic [2*NP-1:0] phase_sig;
  logic [1:0]      active_phase;
  logic [2:0]      state;
  logic [NP-1:0]   pending;
  logic            phase_start;
`ifdef TLC_FLASH_EN
  logic            flash = 1'b0;
`endif

  tlc_phase_ctrl #(
    .NUM_PHASES(NP), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW(YEL), .ALL_RED(AR), .CNT_W(CW)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
`ifdef TLC_FLASH_EN
    .flash(flash),
`endif
    .demand(demand),
    .phase_sig(phase_sig),
    .active_phase(active_phase),
    .state(state),
    .pending(pending),
    .phase_start(phase_start)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;

  // Reference model: stage, time spent in it, served phase, stored successor, latched demand.
  int            m_stg, m_age, m_ph, m_nxt;
  logic [NP-1:0] m_pend;
  logic          m_start;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
    end
  endtask

  function automatic logic [2*NP-1:0] exp_sig();
    logic [2*NP-1:0] s;
    s = '0;
    if (m_stg == S_GRN)      s[2*m_ph +: 2] = 2'b10;
    else if (m_stg == S_YEL) s[2*m_ph +: 2] = 2'b01;
    return s;
  endfunction

  task automatic model_reset();
    m_stg = S_INIT; m_age = 0; m_ph = 0; m_nxt = 0; m_pend = '0; m_start = 1'b0;
  endtask

  task automatic model_step(input logic [NP-1:0] d);
    logic [NP-1:0] np_;
    int ns, nph;
    bit other, leave, found;
    np_ = m_pend | d;
    if (m_stg == S_GRN) np_[m_ph] = m_pend[m_ph];
    ns = m_stg; nph = m_ph; m_start = 1'b0;
    case (m_stg)
      S_INIT, S_RED: if (m_age == AR - 1) begin
        ns = S_GRN;
        nph = (m_stg == S_INIT) ? 0 : m_nxt;
      end
      S_GRN: begin
        other = 0;
        for (int j = 0; j < NP; j++) if (j != m_ph && m_pend[j]) other = 1;
        leave = 0;
        if (m_age >= GMIN - 1)
          leave = other || (m_ph != 0 && !d[m_ph]) || (m_age == GMAX - 1 && (other || m_ph != 0));
        if (leave) begin
          ns = S_YEL; m_nxt = 0; found = 0;
          for (int k = 1; k < NP; k++)
            if (!found && np_[(m_ph + k) % NP]) begin m_nxt = (m_ph + k) % NP; found = 1; end
        end
      end
      S_YEL: if (m_age == YEL - 1) ns = S_RED;
      default: ;
    endcase
    if (ns == S_GRN && m_stg != S_GRN) begin np_[nph] = 1'b0; m_start = 1'b1; end
    m_age  = (ns != m_stg) ? 0 : m_age + 1;
    m_stg  = ns;
    m_ph   = nph;
    m_pend = np_;
  endtask

  task automatic cyc(input logic [NP-1:0] d);
    chk("sig",   32'(phase_sig),    32'(exp_sig()));
    chk("state", 32'(state),        32'(m_stg));
    chk("act",   32'(active_phase), 32'(m_ph));
    chk("pend",  32'(pending),      32'(m_pend));
    chk("start", 32'(phase_start),  32'(m_start));
    demand = d;
    model_step(d);
    cyc_n++;
    @(negedge Clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(state),        32'd0);
    chk({tag, "_sig"},   32'(phase_sig),    32'd0);
    chk({tag, "_pend"},  32'(pending),      32'd0);
    chk({tag, "_act"},   32'(active_phase), 32'd0);
    chk({tag, "_start"}, 32'(phase_start),  32'd0);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    demand = '0;
    repeat (2) @(negedge Clk);
    chk_zero("rst");
    Rst_n = 1'b1;
    model_reset();
    cyc_n = 0;
  endtask

  task automatic async_rst();
    #2;
    Rst_n = 1'b0;
    demand = '0;
    #1;
    chk_zero("arst");
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
    cyc_n = 0;
  endtask

  initial begin
    logic [NP-1:0] d;
    int rate;

    // Idle: phase 0 rests green, then a late demand exits on the long-rested counter.
    do_reset();
    for (int c = 0; c < 215; c++) begin
      if (c == 0)   chk("idle_red0", 32'(phase_sig), 32'h00);
      if (c == 2)   chk("idle_start", 32'(phase_start), 32'd1);
      if (c == 2)   chk("idle_g2", 32'(phase_sig), 32'h02);
      if (c == 199) chk("idle_g199", 32'(phase_sig), 32'h02);
      if (c == 202) chk("late_yel", 32'(state), 32'd2);
      cyc((c == 200) ? 4'b0010 : 4'b0000);
    end

    // Single pulse on phase 2, then phases 1..3 held for round-robin service.
    do_reset();
    for (int c = 0; c < 60; c++) begin
      if (c == 4)  chk("pulse_pend", 32'(pending), 32'h4);
      if (c == 12) chk("pulse_y12", 32'(phase_sig), 32'h01);
      if (c == 15) chk("pulse_y15", 32'(phase_sig), 32'h01);
      if (c == 16) chk("pulse_r16", 32'(phase_sig), 32'h00);
      if (c == 18) chk("pulse_g18", 32'(phase_sig), 32'h20);
      if (c == 18) chk("pulse_pend18", 32'(pending), 32'h0);
      if (c == 27) chk("rr_g27", 32'(state), 32'd1);
      if (c == 28) chk("rr_y28", 32'(state), 32'd2);
      if (c == 34) chk("rr_ph3", 32'(active_phase), 32'd3);
      if (c == 50) chk("rr_ph1", 32'(active_phase), 32'd1);
      cyc((c == 3) ? 4'b0100 : ((c >= 18) ? 4'b1110 : 4'b0000));
    end

    // Max green: phase 1 held with no competitor ends after exactly GREEN_MAX cycles.
    do_reset();
    for (int c = 0; c < 70; c++) begin
      if (c == 18) chk("max_ph1", 32'(active_phase), 32'd1);
      if (c == 57) chk("max_g57", 32'(state), 32'd1);
      if (c == 58) chk("max_y58", 32'(state), 32'd2);
      if (c == 64) chk("max_ph0", 32'(phase_sig), 32'h02);
      cyc(4'b0010);
    end

    // Demand drop on phase 3 at cnt 20.
    do_reset();
    for (int c = 0; c < 55; c++) begin
      if (c == 38) chk("drop_g38", 32'(state), 32'd1);
      if (c == 39) chk("drop_y39", 32'(state), 32'd2);
      if (c == 45) chk("drop_ph0", 32'(phase_sig), 32'h02);
      cyc((c < 38) ? 4'b1000 : 4'b0000);
    end

    // Randomized level demand with varying activity, plus mid-run asynchronous resets.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      d = '0;
      rate = 4 + seg * 6;
      for (int c = 0; c < 500; c++) begin
        if (seg[0] && c == 250) async_rst();
        for (int b = 0; b < NP; b++)
          if ($urandom_range(rate - 1) == 0) d[b] = ~d[b];
        cyc((seg == 5 && c < 150) ? 4'b0000 : d);
      end
    end

`ifdef TLC_FLASH_EN
    flash = 1'b1;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (c < 2)
        chk("fl_red", 32'(phase_sig), 32'h00);
      else if (c <= 12)
        chk("fl_tog", 32'(phase_sig), (((c - 2) / 4) % 2 == 1) ? 32'h03 : 32'h01);
      if (c == 12) chk("fl_state", 32'(state), 32'(S_FLS));
      if (c == 13 || c == 14) chk("fl_ar", 32'(state), 32'(S_RED));
      if (c == 15) chk("fl_g", 32'(phase_sig), 32'h02);
      if (c == 12) flash = 1'b0;
      cyc_n++;
      @(negedge Clk);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
